// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Walks a 4-input combinational circuit through all 16 input vectors and
// captures its Y output into a 16-bit truth table. It then compares that
// table with a reference.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before Y is sampled (1..15)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : sweep request, only honoured while idle
//   abcd       : vector to the circuit under test (bit3=A .. bit0=D)
//   y_in       : Y returned by the circuit under test
//   expected   : reference truth table, bit i = expected Y for abcd==i
//   busy       : high while vectors are being driven/sampled
//   done       : one-cycle pulse when a sweep completes
//   table_out  : captured truth table, bit i = Y sampled for abcd==i
//   ones_count : number of ones captured (0..16)
//   match      : table_out == expected, valid from the done cycle
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        y_in,
    input  logic [15:0] expected,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_count,
    output logic        match
);

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned TBL_W    = 16;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [IDX_W-1:0]    LAST_INDEX  = IDX_W'(TBL_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweepState_e;

    sweepState_e         state;
    sweepState_e         stateNext;

    logic [IDX_W-1:0]    indexQ;
    logic [IDX_W-1:0]    indexNext;
    logic [SETTLE_W-1:0] settleCnt;
    logic [SETTLE_W-1:0] settleNext;
    logic [TBL_W-1:0]    tableQ;
    logic [TBL_W-1:0]    tableNext;
    logic [TBL_W-1:0]    sampledTable;
    logic [CNT_W-1:0]    onesQ;
    logic [CNT_W-1:0]    onesNext;
    logic                matchQ;
    logic                matchNext;
    logic                busyQ;
    logic                busyNext;
    logic                doneQ;
    logic                doneNext;

    // State and datapath registers; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            indexQ    <= '0;
            settleCnt <= '0;
            tableQ    <= '0;
            onesQ     <= '0;
            matchQ    <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            indexQ    <= indexNext;
            settleCnt <= settleNext;
            tableQ    <= tableNext;
            onesQ     <= onesNext;
            matchQ    <= matchNext;
            busyQ     <= busyNext;
            doneQ     <= doneNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = DRIVE;
                end
            end
            DRIVE: begin
                if (settleCnt == SETTLE_LAST) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                stateNext = (indexQ == LAST_INDEX) ? DONE : DRIVE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath and output next values.
    // The final sample is merged into the table before the comparison, so match
    // is registered on the edge into DONE and is already valid alongside done.
    always_comb begin
        indexNext    = indexQ;
        settleNext   = settleCnt;
        tableNext    = tableQ;
        onesNext     = onesQ;
        matchNext    = matchQ;
        sampledTable = tableQ;
        sampledTable[indexQ] = y_in;

        case (state)
            IDLE: begin
                if (start) begin
                    indexNext  = '0;
                    settleNext = '0;
                    tableNext  = '0;
                    onesNext   = '0;
                    matchNext  = 1'b0;
                end
            end
            DRIVE: begin
                if (settleCnt != SETTLE_LAST) begin
                    settleNext = settleCnt + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                tableNext = sampledTable;
                // At most 16 increments per sweep, so 5 bits never wrap.
                onesNext  = onesQ + CNT_W'(y_in);
                if (indexQ != LAST_INDEX) begin
                    indexNext  = indexQ + IDX_W'(1);
                    settleNext = '0;
                end else begin
                    matchNext = (sampledTable == expected);
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase

        busyNext = (stateNext == DRIVE) || (stateNext == SAMPLE);
        doneNext = (stateNext == DONE);
    end

    assign abcd       = indexQ;
    assign busy       = busyQ;
    assign done       = doneQ;
    assign table_out  = tableQ;
    assign ones_count = onesQ;
    assign match      = matchQ;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// Testbench for truth_table_sweeper. Two instances: SETTLE_CYCLES=1 (index 0)
// and SETTLE_CYCLES=3 (index 1). The downstream circuit is modelled per
// instance: tied 0, tied 1, Y=A, or a random 16-entry lookup table.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        start    [2];
    logic [3:0]  abcd     [2];
    logic        yIn      [2];
    logic [15:0] expected [2];
    logic        busy     [2];
    logic        done     [2];
    logic [15:0] tableOut [2];
    logic [4:0]  onesCount[2];
    logic        match    [2];

    int          yMode    [2];
    logic [15:0] randTab  [2];

    int checks = 0;
    int fails  = 0;

    function automatic logic yFor(input int mode, input logic [15:0] tab, input logic [3:0] v);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[3];
            default: return tab[v];
        endcase
    endfunction

    // Full truth table the circuit model implies, built vector by vector.
    function automatic logic [15:0] refTable(input int mode, input logic [15:0] tab);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[i] = yFor(mode, tab, 4'(i));
        end
        return t;
    endfunction

    assign yIn[0] = yFor(yMode[0], randTab[0], abcd[0]);
    assign yIn[1] = yFor(yMode[1], randTab[1], abcd[1]);

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .abcd(abcd[0]), .y_in(yIn[0]),
        .expected(expected[0]), .busy(busy[0]), .done(done[0]),
        .table_out(tableOut[0]), .ones_count(onesCount[0]), .match(match[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .abcd(abcd[1]), .y_in(yIn[1]),
        .expected(expected[1]), .busy(busy[1]), .done(done[1]),
        .table_out(tableOut[1]), .ones_count(onesCount[1]), .match(match[1])
    );

    // Called at a negedge. Requests a sweep, follows it cycle by cycle and
    // returns at the negedge of the IDLE cycle after done.
    task automatic runSweep(input int d, input logic [15:0] exp, input bit keepStart, input string name);
        int          per;
        int          total;
        logic [15:0] want;
        logic [4:0]  wantOnes;
        logic        wantMatch;
        per       = (d == 0) ? 2 : 4;
        total     = 16 * per;
        want      = refTable(yMode[d], randTab[d]);
        wantOnes  = 5'($countones(want));
        wantMatch = (want == exp);
        expected[d] = exp;
        start[d]    = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= total; n++) begin
            @(negedge clk);
            if (n == 0 && !keepStart) start[d] = 1'b0;
            checks++;
            if (n < total) begin
                if (busy[d] !== 1'b1 || done[d] !== 1'b0 || abcd[d] !== 4'(n / per)) begin
                    fails++;
                    $display("FAIL %s run cycle %0d: busy=%b done=%b abcd=%h, want busy=1 done=0 abcd=%h",
                             name, n, busy[d], done[d], abcd[d], 4'(n / per));
                end
            end else begin
                if (done[d] !== 1'b1 || busy[d] !== 1'b0 || abcd[d] !== 4'hF) begin
                    fails++;
                    $display("FAIL %s done cycle: done=%b busy=%b abcd=%h, want 1 0 f",
                             name, done[d], busy[d], abcd[d]);
                end
                checks++;
                if (tableOut[d] !== want) begin
                    fails++;
                    $display("FAIL %s table: got %h want %h", name, tableOut[d], want);
                end
                checks++;
                if (onesCount[d] !== wantOnes) begin
                    fails++;
                    $display("FAIL %s ones: got %0d want %0d", name, onesCount[d], wantOnes);
                end
                checks++;
                if (match[d] !== wantMatch) begin
                    fails++;
                    $display("FAIL %s match: got %b want %b", name, match[d], wantMatch);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done[d] !== 1'b0 || busy[d] !== 1'b0 || tableOut[d] !== want ||
            onesCount[d] !== wantOnes || match[d] !== wantMatch) begin
            fails++;
            $display("FAIL %s after done: done=%b busy=%b table=%h ones=%0d match=%b, want 0 0 %h %0d %b",
                     name, done[d], busy[d], tableOut[d], onesCount[d], match[d],
                     want, wantOnes, wantMatch);
        end
    endtask

    task automatic checkIdleZero(input int d, input string name);
        checks++;
        if (abcd[d] !== 4'h0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
            tableOut[d] !== 16'h0 || onesCount[d] !== 5'd0 || match[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s: abcd=%h busy=%b done=%b table=%h ones=%0d match=%b, want all 0",
                     name, abcd[d], busy[d], done[d], tableOut[d], onesCount[d], match[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; expected[d] = 16'h0; yMode[d] = 1; randTab[d] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) checkIdleZero(d, "reset");
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkIdleZero(d, "idle_no_start");
    endtask

    task automatic test_all_ones();
        yMode[0] = 1;
        runSweep(0, 16'hFFFF, 1'b0, "all_ones");
    endtask

    task automatic test_msb();
        yMode[0] = 2;
        runSweep(0, 16'hFF00, 1'b0, "msb_match");
        runSweep(0, 16'h00FF, 1'b0, "msb_nomatch");
    endtask

    task automatic test_settle3();
        yMode[1] = 0;
        runSweep(1, 16'h0000, 1'b0, "settle3_zero");
        yMode[1] = 2;
        runSweep(1, 16'hFF00, 1'b0, "settle3_msb");
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int i = 0; i < 6; i++) begin
            int d;
            d = i % 2;
            yMode[d]   = 3;
            randTab[d] = 16'($urandom);
            exp = ($urandom_range(0, 1) == 1) ? refTable(3, randTab[d]) : 16'($urandom);
            runSweep(d, exp, 1'b0, "random");
        end
    endtask

    // Expected changes while idle must not disturb held results.
    task automatic test_idle_hold();
        logic [15:0] t;
        logic [4:0]  o;
        logic        m;
        yMode[0] = 2;
        runSweep(0, 16'hFF00, 1'b0, "hold_setup");
        t = refTable(2, 16'h0);
        o = 5'($countones(t));
        m = 1'b1;
        expected[0] = 16'h1234;
        repeat (4) @(negedge clk);
        checks++;
        if (tableOut[0] !== t || onesCount[0] !== o || match[0] !== m || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: table=%h ones=%0d match=%b busy=%b, want %h %0d %b 0",
                     tableOut[0], onesCount[0], match[0], busy[0], t, o, m);
        end
    endtask

    task automatic test_back_to_back();
        yMode[0] = 1;
        runSweep(0, 16'hFFFF, 1'b1, "b2b_first");
        runSweep(0, 16'hFFFF, 1'b1, "b2b_second");
        start[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_stop cycle %0d: busy=%b done=%b, want 0 0", n, busy[0], done[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        yMode[0] = 1;
        expected[0] = 16'hFFFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (abcd[0] === 4'h7) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reset_reach7: abcd=%h, want 7 within 200 cycles", abcd[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checkIdleZero(0, "mid_reset");
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_quiet cycle %0d: done=%b busy=%b, want 0 0", n, done[0], busy[0]);
            end
        end
        yMode[0] = 3;
        randTab[0] = 16'hA5C3;
        runSweep(0, 16'hA5C3, 1'b0, "after_reset");
    endtask

    task automatic test_rst_start();
        rst[1] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        start[1] = 1'b0;
        checkIdleZero(1, "rst_start");
        @(negedge clk);
        checkIdleZero(1, "rst_start_next");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_msb();
        test_settle3();
        test_random();
        test_idle_hold();
        test_back_to_back();
        test_mid_reset();
        test_rst_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
